// File: rtl/s2_pkg.sv
// Shared definitions for the stage-2 result buffer.
// Constants for buffer geometry, the signed element type, the buffer address
// helper (also used by the stage-2 writer) and the pool reader state type.
package s2_pkg;
  localparam int NCH   = 4;                 // channels (filters)
  localparam int DIM   = 6;                 // input feature-map side
  localparam int WIDTH = 35;                // signed element width
  localparam int PDIM  = DIM / 2;           // pooled side
  localparam int NELEM = NCH * DIM * DIM;   // buffer depth
  localparam int AW    = $clog2(NELEM);     // buffer address width
  localparam int CHW   = $clog2(NCH);       // channel counter width
  localparam int PW    = $clog2(PDIM);      // pooled row/col counter width

  typedef logic signed [WIDTH-1:0] s2_feat_t;

  typedef enum logic [1:0] {IDLE, ACC, SEND, DONE} state_t;

  // Flat buffer address of element (ch,row,col); row/col in input coordinates.
  function automatic logic [AW-1:0] s2_addr(input int ch, input int row, input int col);
    return AW'(ch * DIM * DIM + row * DIM + col);
  endfunction
endpackage

// File: rtl/pool_window_ctr.sv
// Window walker for the pool reader.
//   clk, reset : clock, synchronous active-high reset
//   clear      : force all counters to 0
//   k_adv      : step the in-window element index k (wraps 3 -> 0)
//   win_adv    : step to the next window, col inner, then row, then ch
//   k, col, row, ch : current position; last_win flags the final window
module pool_window_ctr
  import s2_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           clear,
  input  logic           k_adv,
  input  logic           win_adv,
  output logic [1:0]     k,
  output logic [PW-1:0]  col,
  output logic [PW-1:0]  row,
  output logic [CHW-1:0] ch,
  output logic           last_win
);
  assign last_win = (ch == CHW'(NCH - 1)) && (row == PW'(PDIM - 1)) && (col == PW'(PDIM - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      k   <= '0;
      col <= '0;
      row <= '0;
      ch  <= '0;
    end else begin
      if (k_adv) k <= k + 2'd1;
      if (win_adv) begin
        if (col == PW'(PDIM - 1)) begin
          col <= '0;
          if (row == PW'(PDIM - 1)) begin
            row <= '0;
            ch  <= (ch == CHW'(NCH - 1)) ? '0 : ch + CHW'(1);
          end else begin
            row <= row + PW'(1);
          end
        end else begin
          col <= col + PW'(1);
        end
      end
    end
  end
endmodule

// File: rtl/s2_pool_reader.sv
// Stage-2 buffer reader with 2x2 / stride-2 max pooling.
// Walks all NCH*PDIM*PDIM windows (ch outer, col inner), comparing the four
// window elements one per cycle, then presents the max on a valid/ready port.
//   clk, reset          : clock, synchronous active-high reset
//   start               : buffer complete, sampled in IDLE only
//   feat_in             : whole stage-2 buffer, stable while busy
//   out_valid/out_ready : result handshake
//   out_data            : pooled max; out_ch/out_row/out_col its position
//   busy                : pass in progress; done: one-cycle end-of-pass pulse
module s2_pool_reader
  import s2_pkg::*;
(
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NELEM-1:0][WIDTH-1:0] feat_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output s2_feat_t                    out_data,
  output logic [CHW-1:0]              out_ch,
  output logic [PW-1:0]               out_row,
  output logic [PW-1:0]               out_col,
  output logic                        busy,
  output logic                        done
);
  state_t         state, nxt;
  logic [1:0]     k;
  logic [CHW-1:0] ch;
  logic [PW-1:0]  row, col;
  logic           last_win;
  logic           hs;
  logic [AW-1:0]  addr;
  s2_feat_t       elem, acc, mx;

  // Outputs decode the registered state, so ready never reaches valid.
  assign out_valid = (state == SEND);
  assign busy      = (state == ACC) || (state == SEND);
  assign done      = (state == DONE);
  assign hs        = out_valid && out_ready;

  pool_window_ctr u_ctr (
    .clk      (clk),
    .reset    (reset),
    .clear    (state == IDLE),
    .k_adv    (state == ACC),
    .win_adv  (hs),
    .k        (k),
    .col      (col),
    .row      (row),
    .ch       (ch),
    .last_win (last_win)
  );

  // k[1] picks the lower row of the window, k[0] the right column.
  assign addr = s2_addr(int'(ch), 2 * int'(row) + int'(k[1]), 2 * int'(col) + int'(k[0]));
  assign elem = $signed(feat_in[addr]);
  // Strict greater-than: on a tie the earlier element is kept.
  assign mx   = (elem > acc) ? elem : acc;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = ACC;
      ACC:     if (k == 2'd3) nxt = SEND;
      SEND:    if (out_ready) nxt = last_win ? DONE : ACC;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      out_data <= '0;
      out_ch   <= '0;
      out_row  <= '0;
      out_col  <= '0;
    end else if (state == ACC) begin
      acc <= (k == 2'd0) ? elem : mx;
      if (k == 2'd3) begin
        out_data <= mx;
        out_ch   <= ch;
        out_row  <= row;
        out_col  <= col;
      end
    end
  end
endmodule

// File: tb/tb_s2_pool_reader.sv
module tb_s2_pool_reader;
  import s2_pkg::*;

  logic                        clk = 0;
  logic                        reset = 0;
  logic                        start = 0;
  logic [NELEM-1:0][WIDTH-1:0] feat = '0;
  logic                        out_valid;
  logic                        out_ready = 0;
  logic signed [WIDTH-1:0]     out_data;
  logic [CHW-1:0]              out_ch;
  logic [PW-1:0]               out_row, out_col;
  logic                        busy, done;

  s2_pool_reader dut (
    .clk(clk), .reset(reset), .start(start), .feat_in(feat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_row(out_row), .out_col(out_col),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", nm, got, exp, cyc);
    end
  endtask

  // Reference: pooled results listed in stream order.
  typedef struct { longint d; int ch; int row; int col; } exp_t;
  exp_t q[$];

  function automatic longint fv(int ch, int r, int c);
    logic [WIDTH-1:0] raw;
    raw = feat[ch * DIM * DIM + r * DIM + c];
    return longint'($signed(raw));
  endfunction

  task automatic build_exp();
    exp_t e;
    q.delete();
    for (int ch = 0; ch < NCH; ch++)
      for (int r = 0; r < PDIM; r++)
        for (int c = 0; c < PDIM; c++) begin
          longint m;
          m = fv(ch, 2 * r, 2 * c);
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++)
              if (fv(ch, 2 * r + dr, 2 * c + dc) > m) m = fv(ch, 2 * r + dr, 2 * c + dc);
          e.d = m; e.ch = ch; e.row = r; e.col = c;
          q.push_back(e);
        end
  endtask

  // Per-pass observations gathered by the compare process.
  int     nhs, ndone, first_vld, done_cyc, t_start;
  longint got[64];
  int     hs_cyc[64];
  logic   pv = 0, pr = 0;
  longint pd;
  int     ppos;

  always @(negedge clk) begin
    if (reset) pv = 0;
    else begin
      if (out_valid) chk("valid_implies_busy", busy, 1);
      if (pv && !pr) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, pd);
        chk("stall_pos", {out_ch, out_row, out_col}, ppos);
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL extra_output got=%0d exp=none", out_data);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data", out_data, e.d);
          chk("ch", out_ch, e.ch);
          chk("row", out_row, e.row);
          chk("col", out_col, e.col);
        end
        if (nhs < 64) begin
          got[nhs] = out_data;
          hs_cyc[nhs] = cyc + 1;   // edge on which this handshake completes
        end
        nhs++;
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      ppos = int'({out_ch, out_row, out_col});
    end
  end

  // Inputs change 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_pass();
    nhs = 0; ndone = 0; first_vld = -1; done_cyc = -1;
    build_exp();
  endtask

  task automatic kick();
    start = 1;
    t_start = cyc + 1;   // edge that samples start ("T")
    step();
    start = 0;
  endtask

  task automatic wait_done(input string nm);
    for (int i = 0; i < 600 && ndone == 0; i++) step();
    chk(nm, ndone, 1);
    step();
  endtask

  task automatic load_ramp();
    for (int a = 0; a < NELEM; a++) feat[a] = WIDTH'(a);
  endtask

  initial begin
    // Reset, with start asserted throughout
    step();
    reset = 1; start = 1;
    step(); step();
    chk("rst_ctl", {out_valid, busy, done}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_pos", {out_ch, out_row, out_col}, 0);
    reset = 0; start = 0;
    step(); step();
    chk("start_in_reset_ignored", busy, 0);

    // Ramp pass, ready tied high
    load_ramp();
    out_ready = 1;
    new_pass();
    kick();
    wait_done("ramp_done");
    chk("ramp_count", nhs, 36);
    chk("ramp_first", got[0], 7);
    chk("ramp_second", got[1], 9);
    chk("ramp_last", got[35], 143);
    chk("ramp_first_valid_lat", first_vld - t_start, 4);
    chk("ramp_first_hs", hs_cyc[0] - t_start, 5);
    chk("ramp_done_lat", done_cyc - t_start, 180);
    chk("ramp_q_empty", q.size(), 0);

    // Signed values and ties
    load_ramp();
    feat[50] = WIDTH'(-5); feat[51] = WIDTH'(-3);
    feat[56] = WIDTH'(-3); feat[57] = WIDTH'(-9);
    feat[72] = '1; feat[73] = '1; feat[78] = '1; feat[79] = '1;
    new_pass();
    kick();
    wait_done("neg_done");
    chk("neg_count", nhs, 36);
    chk("neg_tie_win13", got[13], -3);
    chk("neg_all_m1_win18", got[18], -1);

    // Back-pressure on window 4
    load_ramp();
    new_pass();
    kick();
    for (int i = 0; i < 200; i++) begin
      if (out_valid && nhs == 4) break;
      step();
    end
    out_ready = 0;
    repeat (10) step();
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 21);
    chk("bp_pos", {out_ch, out_row, out_col}, {2'd0, 2'd1, 2'd1});
    chk("bp_no_advance", nhs, 4);
    out_ready = 1;
    wait_done("bp_done");
    chk("bp_count", nhs, 36);
    chk("bp_stall_gap", hs_cyc[4] - hs_cyc[3], 15);
    chk("bp_next_gap", hs_cyc[5] - hs_cyc[4], 5);

    // Abort at window 20, then a clean restart
    new_pass();
    kick();
    for (int i = 0; i < 400 && nhs < 20; i++) step();
    reset = 1; out_ready = 0;
    step(); step();
    chk("abort_ctl", {out_valid, busy, done}, 0);
    chk("abort_data", out_data, 0);
    chk("abort_pos", {out_ch, out_row, out_col}, 0);
    reset = 0;
    repeat (3) step();
    chk("abort_no_done", ndone, 0);
    out_ready = 1;
    new_pass();
    kick();
    wait_done("restart_done");
    chk("restart_count", nhs, 36);
    chk("restart_first", got[0], 7);
    chk("restart_last", got[35], 143);

    // Start pulses while busy and in the DONE cycle
    new_pass();
    kick();
    for (int i = 0; i < 400; i++) begin
      step();
      if (done) begin
        start = 1;
        break;
      end
      start = busy && (cyc % 7 == 0);
    end
    step();
    start = 0;
    repeat (20) step();
    chk("restart_ignored_busy", busy, 0);
    chk("restart_ignored_valid", out_valid, 0);
    chk("one_done", ndone, 1);
    chk("one_pass_count", nhs, 36);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=%0d exp=finish", cyc);
    $fatal(1, "timeout");
  end
endmodule
